hazard_scoreboard: RTL and testbench

- Producer-side companion to the operand-forwarding logic: records every in-flight register write from the moment it issues until its result is forwardable.
- Stalls decode when a source register's result cannot yet be supplied by forwarding, such as load-use or multi-cycle ALU ops.
- Sits between decode and execute. Its stall output freezes the PC and the IF/ID register, and inserts a bubble into ID/EX.

---
 rtl/hazard_scoreboard.sv | 101 ++++++++++
 tb/tb_hazard_scoreboard.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes until they become
// forwardable and stalls decode on a source operand that is still pending.
// Each architectural register owns a small countdown. It is loaded with the
// producer's latency at issue and decrements once per cycle. A nonzero count
// means forwarding cannot yet supply the value.
// Optional build macro: HAZARD_STALL_PERF_EN adds a saturating stall-cycle
// counter (stall_cycles) with a synchronous clear input (perf_clr).
//
// Handshake: issue_valid requests that the decode instruction advance to
// execute. The issue takes effect only in a cycle where issue_accept is high,
// that is issue_valid && !stall && !flush while out of reset. A stalled
// instruction is held in decode by the surrounding pipeline. A bubble goes
// into ID/EX, so a stalled instruction never creates an entry.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                issue_valid,
  input  logic                issue_we,
  input  logic [4:0]          issue_rd,
  input  logic [LAT_W-1:0]    issue_lat,
  input  logic [4:0]          decode_RS,
  input  logic [4:0]          decode_RT,
  input  logic                use_rs,
  input  logic                use_rt,
  input  logic                flush,
`ifdef HAZARD_STALL_PERF_EN
  input  logic                perf_clr,
  output logic [31:0]         stall_cycles,
`endif
  output logic                stall,
  output logic                issue_accept,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [LAT_W-1:0] cnt [NUM_REGS];

  // Busy flags come straight from the countdown state. Register 0 never holds an entry.
  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      busy_vec[i] = |cnt[i];
    end
  end

  // A source operand stalls decode while its producer is still counting down.
  always_comb begin
    stall = (use_rs && (decode_RS != 5'd0) && busy_vec[decode_RS]) ||
            (use_rt && (decode_RT != 5'd0) && busy_vec[decode_RT]);
  end

  // The issue takes effect only when decode is not held, not flushed and not in reset.
  always_comb begin
    issue_accept = reset_n && issue_valid && !stall && !flush;
  end

  // Per-register countdown with priority flush > new entry > decrement > hold.
  // A new entry keeps the longer of the new latency and the decremented
  // outstanding count, so a WAW never shortens an older, slower write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (flush) begin
          cnt[i] <= '0;
        end else if (issue_accept && issue_we && (issue_rd == 5'(i)) &&
                     (issue_lat != '0)) begin
          if (cnt[i] == '0) begin
            cnt[i] <= issue_lat;
          end else if (issue_lat > (cnt[i] - 1'b1)) begin
            cnt[i] <= issue_lat;
          end else begin
            cnt[i] <= cnt[i] - 1'b1;
          end
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_STALL_PERF_EN
  // Saturating count of stalled cycles. A clear takes priority over counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: vector-table bench for hazard_scoreboard, plus
// hand-written reset and async-reset sequences.
module tb_hazard_scoreboard;

  logic        clk;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_lat;
  logic [4:0]  decode_RS;
  logic [4:0]  decode_RT;
  logic        use_rs;
  logic        use_rt;
  logic        flush;
  logic        stall;
  logic        issue_accept;
  logic [31:0] busy_vec;
`ifdef HAZARD_STALL_PERF_EN
  logic        perf_clr;
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // Expected {stall, issue_accept, busy_vec} for each driven vector
  logic [33:0] exp_q[$];

  typedef struct {
    logic       v;
    logic       we;
    logic [4:0] rd;
    logic [2:0] lat;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       fl;
    logic       e_stall;
    logic       e_acc;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[$];

  hazard_scoreboard #(.NUM_REGS(32), .LAT_W(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_we     (issue_we),
    .issue_rd     (issue_rd),
    .issue_lat    (issue_lat),
    .decode_RS    (decode_RS),
    .decode_RT    (decode_RT),
    .use_rs       (use_rs),
    .use_rt       (use_rt),
    .flush        (flush),
`ifdef HAZARD_STALL_PERF_EN
    .perf_clr     (perf_clr),
    .stall_cycles (stall_cycles),
`endif
    .stall        (stall),
    .issue_accept (issue_accept),
    .busy_vec     (busy_vec)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bit_of(input int n);
    logic [31:0] r;
    r = '0;
    r[n] = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got stall=%0b acc=%0b busy=%08h, expected stall=%0b acc=%0b busy=%08h",
               name, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                       input logic [2:0] lat, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic fl);
    issue_valid = v;  issue_we = we;   issue_rd = rd;  issue_lat = lat;
    decode_RS   = rs; decode_RT = rt;  use_rs = urs;   use_rt = urt;
    flush       = fl;
  endtask

  task automatic add(input logic v, input logic we, input logic [4:0] rd,
                     input logic [2:0] lat, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic fl,
                     input logic es, input logic ea, input logic [31:0] eb);
    vec_t t;
    t.v = v; t.we = we; t.rd = rd; t.lat = lat; t.rs = rs; t.rt = rt;
    t.urs = urs; t.urt = urt; t.fl = fl;
    t.e_stall = es; t.e_acc = ea; t.e_busy = eb;
    vecs.push_back(t);
  endtask

  initial begin
    logic [33:0] e;
    // Vector table: one row per cycle, outputs sampled before the next edge.
    // Basic issue with lat=3, then observe the countdown via stall/busy.
    add(1,1,5,3, 0,0,0,0,0, 0,1,32'h0);
    add(0,0,0,0, 0,0,0,0,0, 0,0,bit_of(5));
    add(0,0,0,0, 5,0,1,0,0, 1,0,bit_of(5));
    add(0,0,0,0, 5,0,1,0,0, 1,0,bit_of(5));
    add(0,0,0,0, 5,0,1,0,0, 0,0,32'h0);
    // Load-use: one stall cycle, then the dependent instruction issues.
    add(1,1,8,1, 0,0,0,0,0, 0,1,32'h0);
    add(1,1,10,0, 8,0,1,0,0, 1,0,bit_of(8));
    add(1,1,10,0, 8,0,1,0,0, 0,1,32'h0);
    // Multi-cycle lat=4 on RT: four stall cycles.
    add(1,1,3,4, 0,0,0,0,0, 0,1,32'h0);
    for (int k = 0; k < 4; k++) add(1,0,0,0, 0,3,0,1,0, 1,0,bit_of(3));
    add(1,0,0,0, 0,3,0,1,0, 0,1,32'h0);
    // Same producer but RT not used: no stall, busy still visible.
    add(1,1,3,4, 0,0,0,0,0, 0,1,32'h0);
    add(1,0,0,0, 0,3,0,0,0, 0,1,bit_of(3));
    for (int k = 0; k < 3; k++) add(0,0,0,0, 0,0,0,0,0, 0,0,bit_of(3));
    add(0,0,0,0, 0,0,0,0,0, 0,0,32'h0);
    // Register zero and zero latency create no entry.
    add(1,1,0,7, 0,0,0,0,0, 0,1,32'h0);
    add(1,1,9,0, 0,0,0,0,0, 0,1,32'h0);
    add(1,0,0,0, 0,9,1,1,0, 0,1,32'h0);
    // WAW: a lat=5 write followed by a lat=1 write keeps count 4.
    add(1,1,4,5, 0,0,0,0,0, 0,1,32'h0);
    add(1,1,4,1, 0,0,0,0,0, 0,1,bit_of(4));
    add(0,0,0,0, 0,0,0,0,0, 0,0,bit_of(4));
    add(0,0,0,0, 0,0,0,0,0, 0,0,bit_of(4));
    add(0,0,0,0, 4,0,1,0,0, 1,0,bit_of(4));
    add(0,0,0,0, 4,0,1,0,0, 1,0,bit_of(4));
    add(0,0,0,0, 4,0,1,0,0, 0,0,32'h0);
    // Flush while stalled on cnt[4]==2 clears the stall in the next cycle.
    add(1,1,4,5, 0,0,0,0,0, 0,1,32'h0);
    add(0,0,0,0, 4,0,1,0,0, 1,0,bit_of(4));
    add(0,0,0,0, 4,0,1,0,0, 1,0,bit_of(4));
    add(0,0,0,0, 4,0,1,0,0, 1,0,bit_of(4));
    add(1,1,6,2, 4,0,1,0,1, 1,0,bit_of(4));
    add(1,0,0,0, 4,0,1,0,0, 0,1,32'h0);
    // Issue together with flush is refused and leaves no entry.
    add(1,1,7,3, 0,0,0,0,1, 0,0,32'h0);
    add(0,0,0,0, 0,7,0,1,0, 0,0,32'h0);

    // Reset held with a live issue request: nothing is accepted or recorded.
    drive(1,1,5,3, 5,5,1,1,0);
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      check("reset_hold", {stall, issue_accept, busy_vec}, 34'h0);
    end
    @(negedge clk);
    drive(0,0,0,0, 0,0,0,0,0);
    reset_n = 1'b1;

    // Apply the table through the expected-result queue
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].we, vecs[i].rd, vecs[i].lat, vecs[i].rs,
            vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].fl);
      exp_q.push_back({vecs[i].e_stall, vecs[i].e_acc, vecs[i].e_busy});
      #2;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL queue_empty: got no expected entry, required one");
      end else begin
        e = exp_q.pop_front();
        check($sformatf("vec%0d", i), {stall, issue_accept, busy_vec}, e);
      end
    end

    // Asynchronous reset mid-operation drops a max-latency entry at once.
    @(negedge clk);
    drive(1,1,12,7, 0,0,0,0,0);
    @(negedge clk);
    drive(0,0,0,0, 12,0,1,0,0);
    #2;
    check("pre_async_reset", {stall, issue_accept, busy_vec}, {1'b1, 1'b0, bit_of(12)});
    reset_n = 1'b0;
    #1;
    check("async_reset", {stall, issue_accept, busy_vec}, 34'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    check("post_async_reset", {stall, issue_accept, busy_vec}, 34'h0);

`ifdef HAZARD_STALL_PERF_EN
    // Four-cycle stall is counted. A clear pulse zeroes the counter.
    @(negedge clk);
    drive(0,0,0,0, 0,0,0,0,0);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    drive(1,1,3,4, 0,0,0,0,0);
    @(negedge clk);
    drive(1,0,0,0, 0,3,0,1,0);
    repeat (4) @(negedge clk);
    drive(0,0,0,0, 0,0,0,0,0);
    #2;
    checks++;
    if (stall_cycles !== 32'd4) begin
      errors++;
      $display("FAIL perf_count: got %0d, expected 4", stall_cycles);
    end
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    #2;
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL perf_clr: got %0d, expected 0", stall_cycles);
    end
    force dut.stall_cycles = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cycles;
    drive(1,1,3,2, 0,0,0,0,0);
    @(negedge clk);
    drive(0,0,0,0, 0,3,0,1,0);
    repeat (2) @(negedge clk);
    drive(0,0,0,0, 0,0,0,0,0);
    #2;
    checks++;
    if (stall_cycles !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL perf_sat: got %08h, expected ffffffff", stall_cycles);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

`ifdef HAZARD_STALL_PERF_EN
  initial perf_clr = 1'b0;
`endif

endmodule
